// File: rtl/seg_pkg.sv
// seg_pkg: shared types and constants for the seven-segment scan controller.
package seg_pkg;

  // Largest digit count the controller supports.
  localparam int MAX_DIGITS = 8;

  // Width of a value bus holding MAX_DIGITS nibbles.
  localparam int MAX_VAL_W = 4 * MAX_DIGITS;

  // Anode pattern with every digit dark; the pins are active-low.
  localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;

  typedef logic [3:0] nibble_t;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

  // Returns nibble idx of a value bus that has been zero-extended to MAX_VAL_W.
  function automatic nibble_t pick_nibble(input logic [MAX_VAL_W-1:0] v,
                                          input logic [2:0]           idx);
    return v[4*idx +: 4];
  endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// scan_timer: tick counter for the scan FSM. expire is high while the count
// equals the terminal value; reload restarts the count from zero.
module scan_timer
  import seg_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         reload,
  input  logic [W-1:0] term,
  output logic         expire,
  output logic [W-1:0] cnt_next
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Count up every cycle; a reload returns the count to zero.
  always_comb begin
    cnt_d = reload ? '0 : cnt_q + W'(1);
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expire   = (cnt_q == term);
  assign cnt_next = cnt_d;

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for a common-anode
// seven-segment display. For each digit it presents the nibble to the shared
// registered decoder, holds all anodes off for BLANK_TICKS cycles, and then
// enables that digit's anode for TICKS_PER_DIGIT cycles. New values are
// staged and only move into the displayed copy at a frame boundary.
// Optional feature: define SEG_LEADING_ZERO_BLANK_EN to keep leading-zero
// digits (other than digit 0) dark.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS      = 4,
  parameter int TICKS_PER_DIGIT = 100000,
  parameter int BLANK_TICKS     = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  output logic                    pending,
  output logic [3:0]              encoded,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic                    frame_done
);

  localparam int VAL_W     = 4 * NUM_DIGITS;
  localparam int MAX_TICKS = (TICKS_PER_DIGIT > BLANK_TICKS) ? TICKS_PER_DIGIT : BLANK_TICKS;
  localparam int CNT_W     = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
  localparam int IDX_W     = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] SHOW_TERM  = CNT_W'(TICKS_PER_DIGIT - 1);
  localparam logic [CNT_W-1:0] BLANK_TERM = CNT_W'(BLANK_TICKS - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);

  scan_state_t           state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [VAL_W-1:0]      shadow_q, shadow_d;
  logic [VAL_W-1:0]      staging_q, staging_d;
  logic                  pending_q, pending_d;
  nibble_t               encoded_q, encoded_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic                  frame_done_q, frame_done_d;

  logic                  boundary;
  logic                  expire;
  logic [CNT_W-1:0]      cnt_next;
  logic [CNT_W-1:0]      timer_term;
  logic [NUM_DIGITS-1:0] dark;

  // The timer runs against the terminal count of the current state and is
  // reloaded exactly when the state changes, which is whenever it expires.
  assign timer_term = (state_q == SHOW) ? SHOW_TERM : BLANK_TERM;

  scan_timer #(
    .W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .reload   (expire),
    .term     (timer_term),
    .expire   (expire),
    .cnt_next (cnt_next)
  );

`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic all_zero;

  // Mark digits whose nibble and every higher nibble are zero; digit 0 always shows.
  always_comb begin
    dark     = '0;
    all_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      all_zero = all_zero & (shadow_q[4*i +: 4] == 4'h0);
      dark[i]  = all_zero;
    end
  end
`else
  // Every digit is shown, leading zeros included.
  always_comb begin
    dark = '0;
  end
`endif

  // Next-state logic for the scan FSM, load handshake and registered outputs.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    staging_d = staging_q;
    pending_d = pending_q;
    encoded_d = encoded_q;
    boundary  = 1'b0;

    case (state_q)
      BLANK: begin
        if (expire) state_d = SHOW;
      end
      SHOW: begin
        if (expire) begin
          state_d = BLANK;
          if (idx_q == LAST_IDX) begin
            idx_d    = '0;
            boundary = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = BLANK;
    endcase

    if (load) begin
      staging_d = value;
      pending_d = 1'b1;
    end

    // A load on the boundary cycle bypasses staging so it lands in this frame.
    if (boundary) begin
      if (load)           shadow_d = value;
      else if (pending_q) shadow_d = staging_q;
      pending_d = 1'b0;
    end

    // The decoder input only moves on BLANK entry, while every anode is off.
    if (state_q == SHOW && state_d == BLANK) begin
      encoded_d = pick_nibble(MAX_VAL_W'(shadow_d), 3'(idx_d));
    end

    anode_d = ANODE_OFF[NUM_DIGITS-1:0];
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (state_d == SHOW && idx_d == IDX_W'(i) && !dark[i]) anode_d[i] = 1'b0;
    end

    // High during the last SHOW cycle of the frame, so the edge closing it is
    // the frame boundary and a load seen alongside it goes straight to shadow.
    frame_done_d = (state_d == SHOW) && (idx_d == LAST_IDX) && (cnt_next == SHOW_TERM);
  end

  // State and output registers; reset blanks the display immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= BLANK;
      idx_q        <= '0;
      shadow_q     <= '0;
      staging_q    <= '0;
      pending_q    <= 1'b0;
      encoded_q    <= '0;
      anode_q      <= ANODE_OFF[NUM_DIGITS-1:0];
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      staging_q    <= staging_d;
      pending_q    <= pending_d;
      encoded_q    <= encoded_d;
      anode_q      <= anode_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign pending    = pending_q;
  assign encoded    = encoded_q;
  assign anode      = anode_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed table-driven bench for seg_scan_ctrl with
// NUM_DIGITS=4, TICKS_PER_DIGIT=4, BLANK_TICKS=2 (6-cycle digit, 24-cycle frame).
// Cycle 0 is the first cycle after reset release.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0;
  logic        pending;
  logic [3:0]  encoded;
  logic [3:0]  anode;
  logic        frame_done;

  int total = 0;
  int bad   = 0;

`ifdef SEG_LEADING_ZERO_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  typedef struct {
    int          cyc;
    logic        ld;
    logic [15:0] val;
    logic [3:0]  an;
    logic [3:0]  enc;
    logic        fd;
    logic        pend;
  } vec_t;

  vec_t tbl[$];

  seg_scan_ctrl #(
    .NUM_DIGITS      (4),
    .TICKS_PER_DIGIT (4),
    .BLANK_TICKS     (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value      (value),
    .load       (load),
    .pending    (pending),
    .encoded    (encoded),
    .anode      (anode),
    .frame_done (frame_done)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  task automatic add(input int c, input logic l, input logic [15:0] v,
                     input logic [3:0] a, input logic [3:0] e,
                     input logic f, input logic p);
    vec_t t;
    t.cyc = c; t.ld = l; t.val = v; t.an = a; t.enc = e; t.fd = f; t.pend = p;
    tbl.push_back(t);
  endtask

  task automatic applyStimulus(input logic l, input logic [15:0] v);
    load  = l;
    value = v;
  endtask

  task automatic checkOutput(input string nm, input int cyc,
                             input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s cycle=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic checkAll(input int cyc, input logic [3:0] a, input logic [3:0] e,
                          input logic f, input logic p);
    checkOutput("anode",      cyc, 16'(anode),      16'(a));
    checkOutput("encoded",    cyc, 16'(encoded),    16'(e));
    checkOutput("frame_done", cyc, 16'(frame_done), 16'(f));
    checkOutput("pending",    cyc, 16'(pending),    16'(p));
  endtask

  initial begin
    int          k;
    logic [3:0]  prev_enc;

    // cycle, load, value, anode, encoded, frame_done, pending
    add(  0, 1'b0, 16'h0000, 4'b1111, 4'h0, 1'b0, 1'b0);
    add(  1, 1'b0, 16'h0000, 4'b1111, 4'h0, 1'b0, 1'b0);
    add(  2, 1'b0, 16'h0000, 4'b1110, 4'h0, 1'b0, 1'b0);
    add(  3, 1'b1, 16'h1234, 4'b1110, 4'h0, 1'b0, 1'b0);
    add(  4, 1'b0, 16'h0000, 4'b1110, 4'h0, 1'b0, 1'b1);
    add(  8, 1'b0, 16'h0000, LZ ? 4'b1111 : 4'b1101, 4'h0, 1'b0, 1'b1);
    add( 23, 1'b0, 16'h0000, LZ ? 4'b1111 : 4'b0111, 4'h0, 1'b1, 1'b1);
    add( 24, 1'b0, 16'h0000, 4'b1111, 4'h4, 1'b0, 1'b0);
    add( 26, 1'b0, 16'h0000, 4'b1110, 4'h4, 1'b0, 1'b0);
    add( 32, 1'b0, 16'h0000, 4'b1101, 4'h3, 1'b0, 1'b0);
    add( 38, 1'b0, 16'h0000, 4'b1011, 4'h2, 1'b0, 1'b0);
    add( 44, 1'b0, 16'h0000, 4'b0111, 4'h1, 1'b0, 1'b0);
    add( 46, 1'b0, 16'h0000, 4'b0111, 4'h1, 1'b0, 1'b0);
    add( 47, 1'b0, 16'h0000, 4'b0111, 4'h1, 1'b1, 1'b0);
    add( 48, 1'b0, 16'h0000, 4'b1111, 4'h4, 1'b0, 1'b0);
    add( 56, 1'b1, 16'hABCD, 4'b1101, 4'h3, 1'b0, 1'b0);
    add( 57, 1'b0, 16'h0000, 4'b1101, 4'h3, 1'b0, 1'b1);
    add( 68, 1'b0, 16'h0000, 4'b0111, 4'h1, 1'b0, 1'b1);
    add( 71, 1'b0, 16'h0000, 4'b0111, 4'h1, 1'b1, 1'b1);
    add( 72, 1'b0, 16'h0000, 4'b1111, 4'hD, 1'b0, 1'b0);
    add( 74, 1'b0, 16'h0000, 4'b1110, 4'hD, 1'b0, 1'b0);
    add( 80, 1'b0, 16'h0000, 4'b1101, 4'hC, 1'b0, 1'b0);
    add( 86, 1'b0, 16'h0000, 4'b1011, 4'hB, 1'b0, 1'b0);
    add( 92, 1'b0, 16'h0000, 4'b0111, 4'hA, 1'b0, 1'b0);
    add( 95, 1'b1, 16'h00F0, 4'b0111, 4'hA, 1'b1, 1'b0);
    add( 96, 1'b0, 16'h0000, 4'b1111, 4'h0, 1'b0, 1'b0);
    add( 98, 1'b0, 16'h0000, 4'b1110, 4'h0, 1'b0, 1'b0);
    add(100, 1'b1, 16'h1111, 4'b1110, 4'h0, 1'b0, 1'b0);
    add(101, 1'b0, 16'h0000, 4'b1110, 4'h0, 1'b0, 1'b1);
    add(102, 1'b1, 16'h2222, 4'b1111, 4'hF, 1'b0, 1'b1);
    add(104, 1'b0, 16'h0000, 4'b1101, 4'hF, 1'b0, 1'b1);
    add(110, 1'b0, 16'h0000, LZ ? 4'b1111 : 4'b1011, 4'h0, 1'b0, 1'b1);
    add(116, 1'b0, 16'h0000, LZ ? 4'b1111 : 4'b0111, 4'h0, 1'b0, 1'b1);
    add(119, 1'b0, 16'h0000, LZ ? 4'b1111 : 4'b0111, 4'h0, 1'b1, 1'b1);
    add(120, 1'b0, 16'h0000, 4'b1111, 4'h2, 1'b0, 1'b0);
    add(122, 1'b1, 16'h3333, 4'b1110, 4'h2, 1'b0, 1'b0);
    add(123, 1'b0, 16'h0000, 4'b1110, 4'h2, 1'b0, 1'b1);

    // Reset state while rst_n is held low.
    repeat (2) @(negedge clk);
    checkAll(-1, 4'b1111, 4'h0, 1'b0, 1'b0);

    // Release on a falling edge so the following interval is cycle 0.
    rst_n    = 1'b1;
    k        = 0;
    prev_enc = encoded;
    for (int cyc = 0; cyc <= 123; cyc++) begin
      if (k < tbl.size() && tbl[k].cyc == cyc) begin
        applyStimulus(tbl[k].ld, tbl[k].val);
        checkAll(cyc, tbl[k].an, tbl[k].enc, tbl[k].fd, tbl[k].pend);
        k++;
      end else begin
        applyStimulus(1'b0, 16'h0000);
      end
      checkOutput("anode_onehot", cyc, 16'($countones(~anode) <= 1), 16'd1);
      if (anode !== 4'b1111 && cyc > 0)
        checkOutput("encoded_stable", cyc, 16'(encoded), 16'(prev_enc));
      prev_enc = encoded;
      @(negedge clk);
    end

    // Cycle 124: digit 0 is lit and the 16'h3333 load is still pending.
    checkOutput("pre_reset_anode",   124, 16'(anode),   16'(4'b1110));
    checkOutput("pre_reset_pending", 124, 16'(pending), 16'd1);

    // Asynchronous reset mid-SHOW, well away from any rising edge.
    #2 rst_n = 1'b0;
    #1;
    checkAll(-2, 4'b1111, 4'h0, 1'b0, 1'b0);

    // Release again and confirm digit 0 lights at cycle 2.
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("rerelease_anode_c0", 0, 16'(anode), 16'(4'b1111));
    @(negedge clk);
    checkOutput("rerelease_anode_c1", 1, 16'(anode), 16'(4'b1111));
    @(negedge clk);
    checkAll(2, 4'b1110, 4'h0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
